alu_reservation_station: RTL and testbench
==========================================

// Module: alu_reservation_station
// PURPOSE
//  ALU reservation station. Sits directly downstream of the ID->RS pipeline register.
//  Holds up to DEPTH dispatched ALU ops and wakes operands from the common data bus (CDB).
//  Each cycle it issues the oldest op whose two operands are both ready to the ALU/EX stage.
//  Storage is a compacting queue: slot 0 is always the oldest entry.
// PARAMETERS
//  DEPTH  4  number of entries (>=2)
//  TAGW   5  width of a ROB/rename tag
// PORTS
//  clk           in   1     clock
//  reset         in   1     asynchronous, active-high reset
//  flush         in   1     mispredict flush: drop all entries
//  disp_valid    in   1     dispatch request from ID/RS register
//  disp_ready    out  1     RS can accept (count != DEPTH)
//  disp_alu_op   in   4     ALUOp
//  disp_funct3   in   3     funct3
//  disp_s1_val   in   32    src1 value (valid when disp_s1_rdy)
//  disp_s1_tag   in   TAGW  src1 producer tag (valid when !disp_s1_rdy)
//  disp_s1_rdy   in   1     src1 value already available
//  disp_s2_val/disp_s2_tag/disp_s2_rdy  same for src2
//  disp_imm32    in   32    immediate
//  disp_pc       in   32    instruction PC
//  disp_tag      in   TAGW  destination tag of this op
//  cdb_valid     in   1     result broadcast valid
//  cdb_tag       in   TAGW  broadcast tag
//  cdb_value     in   32    broadcast value
//  iss_valid     out  1     an entry is ready to issue
//  iss_ready     in   1     ALU accepts this cycle
//  iss_alu_op/iss_funct3/iss_s1/iss_s2/iss_imm32/iss_pc/iss_tag  out  selected entry fields
//  count         out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset: all entry valid bits 0, count=0, iss_valid=0, all iss_* data = 0, disp_ready=1.
//  - Accept = disp_valid & disp_ready; Issue = iss_valid & iss_ready. Both act at posedge.
//  - disp_ready = (count != DEPTH). No pass-through when full, even if Issue in same cycle.
//  - Selection: lowest-index entry with s1_rdy & s2_rdy (registered state only). iss_* are
//    combinational from that entry; all iss_* data = 0 when iss_valid=0.
//  - No CDB bypass into issue: an op becomes issuable the cycle after its wakeup.
//    Minimum dispatch->issue latency is 1 cycle.
//  - On Issue, entries above the issued slot shift down by one. An accepted op is written to
//    slot count, or slot count-1 if Issue happens in the same cycle.
//  - count_next = count + Accept - Issue.
//  - Wakeup: when cdb_valid is high, every valid entry operand with rdy=0 and tag==cdb_tag
//    takes val=cdb_value and rdy=1. This also applies to entries that shift this cycle.
//    Operands with rdy=1 are never overwritten.
//  - Dispatch-cycle capture: if disp_sX_rdy=0, cdb_valid is high and disp_sX_tag==cdb_tag,
//    the new entry is written with the operand ready and holding cdb_value.
//  - Flush (priority over Accept, Issue and wakeup): all valid bits cleared, count=0 next
//    cycle. iss_valid may still be 1 during the flush cycle, but the ALU discards that issue.
//  - Reset while occupied: behaves as flush, asynchronously.
// TESTING
//  1 Reset, then dispatch op tag=3, s1/s2 rdy (5,7) -> next cycle iss_valid=1, iss_s1=5, iss_s2=7, iss_tag=3; iss_ready=1 -> count 0.
//  2 Dispatch s1 tag=9 not ready; cdb 9/0xAA two cycles later -> iss_valid rises cycle after CDB, iss_s1=0xAA.
//  3 Dispatch with s2 tag=4 while cdb_valid tag=4 value=0x55 in same cycle -> entry ready, issues next cycle with iss_s2=0x55.
//  4 Fill DEPTH entries with iss_ready=0 -> disp_ready=0, count=DEPTH; 5th disp_valid ignored; one issue -> disp_ready=1 next cycle.
//  5 Entries A(not ready), B(ready), C(ready) -> B issues first, then C; A stays in slot 0; simultaneous dispatch lands at correct slot.
//  6 Three entries and flush together with disp_valid -> count=0, iss_valid=0 next cycle, dispatched op dropped.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station: compacting queue of dispatched ALU ops (slot 0 oldest),
// woken from the CDB, issuing the oldest op whose operands are both ready.
module alu_reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [3:0]                 disp_alu_op,
    input  logic [2:0]                 disp_funct3,
    input  logic [31:0]                disp_s1_val,
    input  logic [TAGW-1:0]            disp_s1_tag,
    input  logic                       disp_s1_rdy,
    input  logic [31:0]                disp_s2_val,
    input  logic [TAGW-1:0]            disp_s2_tag,
    input  logic                       disp_s2_rdy,
    input  logic [31:0]                disp_imm32,
    input  logic [31:0]                disp_pc,
    input  logic [TAGW-1:0]            disp_tag,
    input  logic                       cdb_valid,
    input  logic [TAGW-1:0]            cdb_tag,
    input  logic [31:0]                cdb_value,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [3:0]                 iss_alu_op,
    output logic [2:0]                 iss_funct3,
    output logic [31:0]                iss_s1,
    output logic [31:0]                iss_s2,
    output logic [31:0]                iss_imm32,
    output logic [31:0]                iss_pc,
    output logic [TAGW-1:0]            iss_tag,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [2:0]      funct3;
        logic [31:0]     s1_val;
        logic [TAGW-1:0] s1_tag;
        logic            s1_rdy;
        logic [31:0]     s2_val;
        logic [TAGW-1:0] s2_tag;
        logic            s2_rdy;
        logic [31:0]     imm32;
        logic [31:0]     pc;
        logic [TAGW-1:0] tag;
    } entry_t;

    // Entry data is not reset: an entry is only meaningful below count_q.
    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic [CW-1:0] count_q, count_d;

    logic          accept, issue, iss_found;
    logic [IW-1:0] iss_idx;
    logic [CW-1:0] wr_idx;
    entry_t        disp_e, sel_e;

    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAGW-1:0] t, input logic [31:0] val);
        entry_t r;
        r = e;
        if (v && !e.s1_rdy && e.s1_tag == t) begin
            r.s1_val = val;
            r.s1_rdy = 1'b1;
        end
        if (v && !e.s2_rdy && e.s2_tag == t) begin
            r.s2_val = val;
            r.s2_rdy = 1'b1;
        end
        return r;
    endfunction

    // Oldest ready entry, from registered state only (no CDB bypass into issue).
    always_comb begin
        iss_found = 1'b0;
        iss_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
                iss_found = 1'b1;
                iss_idx   = IW'(i);
            end
        end
    end

    assign sel_e      = ent_q[iss_idx];
    assign iss_valid  = iss_found;
    assign iss_alu_op = iss_found ? sel_e.alu_op : '0;
    assign iss_funct3 = iss_found ? sel_e.funct3 : '0;
    assign iss_s1     = iss_found ? sel_e.s1_val : '0;
    assign iss_s2     = iss_found ? sel_e.s2_val : '0;
    assign iss_imm32  = iss_found ? sel_e.imm32  : '0;
    assign iss_pc     = iss_found ? sel_e.pc     : '0;
    assign iss_tag    = iss_found ? sel_e.tag    : '0;

    assign disp_ready = (count_q != CW'(DEPTH));
    assign count      = count_q;
    assign accept     = disp_valid & disp_ready;
    assign issue      = iss_valid & iss_ready;

    always_comb begin
        disp_e.alu_op = disp_alu_op;
        disp_e.funct3 = disp_funct3;
        disp_e.s1_val = disp_s1_val;
        disp_e.s1_tag = disp_s1_tag;
        disp_e.s1_rdy = disp_s1_rdy;
        disp_e.s2_val = disp_s2_val;
        disp_e.s2_tag = disp_s2_tag;
        disp_e.s2_rdy = disp_s2_rdy;
        disp_e.imm32  = disp_imm32;
        disp_e.pc     = disp_pc;
        disp_e.tag    = disp_tag;
    end

    // Compact over the issued slot, apply wakeup, then append the dispatched op.
    always_comb begin
        wr_idx = issue ? (count_q - CW'(1)) : count_q;
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        if (issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= iss_idx) ent_d[i] = ent_q[i + 1];
            end
        end
        for (int i = 0; i < DEPTH; i++) ent_d[i] = wake(ent_d[i], cdb_valid, cdb_tag, cdb_value);
        if (accept) ent_d[wr_idx[IW-1:0]] = wake(disp_e, cdb_valid, cdb_tag, cdb_value);

        if (flush) count_d = '0;
        else       count_d = count_q + CW'(accept) - CW'(issue);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: reset, wakeup, capture, full, ordering, flush.
module tb_alu_reservation_station;
    logic        clk = 1'b0;
    logic        reset, flush, disp_valid, disp_ready;
    logic [3:0]  disp_alu_op;
    logic [2:0]  disp_funct3;
    logic [31:0] disp_s1_val, disp_s2_val, disp_imm32, disp_pc;
    logic [4:0]  disp_s1_tag, disp_s2_tag, disp_tag;
    logic        disp_s1_rdy, disp_s2_rdy;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_alu_op;
    logic [2:0]  iss_funct3;
    logic [31:0] iss_s1, iss_s2, iss_imm32, iss_pc;
    logic [4:0]  iss_tag;
    logic [2:0]  count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    alu_reservation_station #(.DEPTH(4), .TAGW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_alu_op(disp_alu_op), .disp_funct3(disp_funct3),
        .disp_s1_val(disp_s1_val), .disp_s1_tag(disp_s1_tag), .disp_s1_rdy(disp_s1_rdy),
        .disp_s2_val(disp_s2_val), .disp_s2_tag(disp_s2_tag), .disp_s2_rdy(disp_s2_rdy),
        .disp_imm32(disp_imm32), .disp_pc(disp_pc), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_alu_op(iss_alu_op), .iss_funct3(iss_funct3),
        .iss_s1(iss_s1), .iss_s2(iss_s2), .iss_imm32(iss_imm32),
        .iss_pc(iss_pc), .iss_tag(iss_tag), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving room to drive and settle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic disp(input logic [4:0] tag, input logic [31:0] s1v, input logic [4:0] s1t,
                        input logic s1r, input logic [31:0] s2v, input logic [4:0] s2t,
                        input logic s2r);
        disp_valid  = 1'b1;
        disp_alu_op = 4'h2;
        disp_funct3 = 3'h1;
        disp_s1_val = s1v;
        disp_s1_tag = s1t;
        disp_s1_rdy = s1r;
        disp_s2_val = s2v;
        disp_s2_tag = s2t;
        disp_s2_rdy = s2r;
        disp_imm32  = 32'h100 + 32'(tag);
        disp_pc     = 32'h4000 + 32'(tag);
        disp_tag    = tag;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_value  = '0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; iss_ready = 1'b0;
        disp(5'd0, 0, 0, 1'b0, 0, 0, 1'b0);
        idle();
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        chk("rst_iss_s1", iss_s1, 0);
        chk("rst_iss_tag", 32'(iss_tag), 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: ready op issues the cycle after dispatch
        disp(5'd3, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 1'b1);
        iss_ready = 1'b1;
        #1 chk("t1_no_same_cycle", 32'(iss_valid), 0);
        tick();
        idle();
        #1;
        chk("t1_iss_valid", 32'(iss_valid), 1);
        chk("t1_iss_s1", iss_s1, 5);
        chk("t1_iss_s2", iss_s2, 7);
        chk("t1_iss_tag", 32'(iss_tag), 3);
        chk("t1_iss_pc", iss_pc, 32'h4003);
        chk("t1_count1", 32'(count), 1);
        tick();
        #1 chk("t1_count0", 32'(count), 0);

        // 2: wakeup from CDB, issuable one cycle later
        disp(5'd10, 32'd0, 5'd9, 1'b0, 32'd1, 5'd0, 1'b1);
        tick();
        idle();
        #1 chk("t2_wait", 32'(iss_valid), 0);
        tick();
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'hAA;
        #1 chk("t2_no_bypass", 32'(iss_valid), 0);
        tick();
        idle();
        #1;
        chk("t2_iss_valid", 32'(iss_valid), 1);
        chk("t2_iss_s1", iss_s1, 32'hAA);
        chk("t2_iss_tag", 32'(iss_tag), 10);
        tick();
        #1 chk("t2_count0", 32'(count), 0);

        // 3: operand captured from CDB in the dispatch cycle
        disp(5'd11, 32'd2, 5'd0, 1'b1, 32'd0, 5'd4, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_value = 32'h55;
        tick();
        idle();
        #1;
        chk("t3_iss_valid", 32'(iss_valid), 1);
        chk("t3_iss_s2", iss_s2, 32'h55);
        chk("t3_iss_tag", 32'(iss_tag), 11);
        tick();
        #1 chk("t3_count0", 32'(count), 0);

        // 4: fill to DEPTH, extra dispatch ignored, drain
        iss_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            disp(5'(i), 32'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1);
            tick();
        end
        idle();
        #1;
        chk("t4_count_full", 32'(count), 4);
        chk("t4_not_ready", 32'(disp_ready), 0);
        disp(5'd7, 32'd7, 5'd0, 1'b1, 32'd7, 5'd0, 1'b1);
        iss_ready = 1'b1;
        #1 chk("t4_head_tag", 32'(iss_tag), 1);
        tick();
        idle();
        #1;
        chk("t4_count3", 32'(count), 3);
        chk("t4_ready_again", 32'(disp_ready), 1);
        chk("t4_next_tag", 32'(iss_tag), 2);
        tick();
        #1 chk("t4_tag3", 32'(iss_tag), 3);
        tick();
        #1 chk("t4_tag4", 32'(iss_tag), 4);
        tick();
        #1 chk("t4_drained", 32'(count), 0);

        // 5: out-of-order issue past a blocked head, dispatch during issue
        iss_ready = 1'b0;
        disp(5'd20, 32'd0, 5'd15, 1'b0, 32'd1, 5'd0, 1'b1);
        tick();
        disp(5'd21, 32'd21, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1);
        tick();
        disp(5'd22, 32'd22, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1);
        tick();
        disp(5'd23, 32'd23, 5'd0, 1'b1, 32'd1, 5'd0, 1'b1);
        iss_ready = 1'b1;
        #1;
        chk("t5_count3", 32'(count), 3);
        chk("t5_B_first", 32'(iss_tag), 21);
        tick();
        idle();
        #1;
        chk("t5_C_second", 32'(iss_tag), 22);
        chk("t5_count_keep", 32'(count), 3);
        tick();
        #1 chk("t5_D_third", 32'(iss_tag), 23);
        cdb_valid = 1'b1; cdb_tag = 5'd15; cdb_value = 32'h77;
        tick();
        idle();
        #1;
        chk("t5_A_last", 32'(iss_tag), 20);
        chk("t5_A_s1", iss_s1, 32'h77);
        chk("t5_count1", 32'(count), 1);
        tick();
        #1 chk("t5_count0", 32'(count), 0);

        // 6: flush with a simultaneous dispatch drops everything
        iss_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            disp(5'(i), 32'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1);
            tick();
        end
        disp(5'd9, 32'd9, 5'd0, 1'b1, 32'd9, 5'd0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        #1;
        chk("t6_count0", 32'(count), 0);
        chk("t6_iss_valid", 32'(iss_valid), 0);
        chk("t6_iss_tag_zero", 32'(iss_tag), 0);
        chk("t6_disp_ready", 32'(disp_ready), 1);
        tick();
        #1 chk("t6_still_empty", 32'(count), 0);

        // Asynchronous reset while occupied
        disp(5'd5, 32'd5, 5'd0, 1'b1, 32'd5, 5'd0, 1'b1);
        tick();
        idle();
        #1 chk("ar_count1", 32'(count), 1);
        reset = 1'b1;
        #1;
        chk("ar_count0", 32'(count), 0);
        chk("ar_iss_valid", 32'(iss_valid), 0);
        tick();
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
